// File: rtl/multi_alarm.sv
// Multi-channel alarm clock: keypad time entry, per-channel ringing with
// auto-stop timers and a piezo tone. Optional snooze: MULTI_ALARM_SNOOZE_EN.
module multi_alarm #(
  parameter int N_ALARM    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int TONE_DIV   = 4,
  parameter int RING_SEC   = 60
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               set_en,
  input  logic [2:0]         ch_sel,
  input  logic [11:0]        keypad_in,
  input  logic               tick,
  input  logic [4:0]         cur_hh,
  input  logic [5:0]         cur_mm,
  input  logic [5:0]         cur_ss,
  input  logic               stop,
  input  logic               snooze,
  output logic [N_ALARM-1:0] ringing,
  output logic [N_ALARM-1:0] armed,
  output logic               piezo,
  output logic               entry_busy,
  output logic               entry_err
);
  localparam int CW = $clog2(RING_SEC + 1);
  localparam int DW = $clog2(TONE_DIV + 1);
  localparam logic [1:0] IDLE = 2'd0, DIGIT = 2'd1, CONFIRM = 2'd2;

  logic [11:0] key_prev_q, code_q;
  logic        evt_q;
  logic [1:0]  state_q, state_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  pend_q, pend_d;
  logic        commit, valid, err_q;
  logic [6:0]  c_hh, c_mm, c_ss;
  logic [3:0]  dig_val;
  logic        is_star, is_hash, is_dig, onehot;
  logic [N_ALARM-1:0][4:0]    alm_hh_q;
  logic [N_ALARM-1:0][5:0]    alm_mm_q, alm_ss_q;
  logic [N_ALARM-1:0]         armed_q, ring_q, ring_d;
  logic [N_ALARM-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q;
  logic          piezo_q;

  assign onehot = (keypad_in != '0) && ((keypad_in & (keypad_in - 12'd1)) == '0);

  always_comb begin
    dig_val = 4'd0;
    for (int i = 0; i < 9; i++) if (code_q[i]) dig_val = 4'(i + 1);
    is_star = code_q[9];
    is_hash = code_q[11];
    is_dig  = !is_star && !is_hash;
  end

  // The key that wakes the FSM from IDLE is also interpreted, so entry can start with a digit.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    commit  = 1'b0;
    if (!set_en) begin
      state_d = IDLE;
    end else if (evt_q) begin
      case (state_q)
        IDLE: begin
          dig_d = '0;
          idx_d = '0;
          if (is_dig) begin
            pend_d  = dig_val;
            state_d = CONFIRM;
          end else if (is_star) begin
            commit = 1'b1;
          end else begin
            state_d = DIGIT;
          end
        end
        DIGIT: begin
          if (is_dig) begin
            pend_d  = dig_val;
            state_d = CONFIRM;
          end else if (is_star) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
        CONFIRM: begin
          if (is_dig) begin
            pend_d = dig_val;
          end else if (is_star) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            if (idx_q < 3'd6) begin
              dig_d[idx_q] = pend_q;
              idx_d        = idx_q + 3'd1;
            end
            state_d = DIGIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    c_hh  = 7'(dig_d[0]) * 7'd10 + 7'(dig_d[1]);
    c_mm  = 7'(dig_d[2]) * 7'd10 + 7'(dig_d[3]);
    c_ss  = 7'(dig_d[4]) * 7'd10 + 7'(dig_d[5]);
    valid = (c_hh < 7'd24) && (c_mm < 7'd60) && (c_ss < 7'd60) && (int'(ch_sel) < N_ALARM);
  end

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [N_ALARM-1:0] snz_mask_q;
  logic [4:0] snz_hh_q;
  logic [5:0] snz_mm_q, snz_ss_q;
  logic [6:0] s_mm;
  logic [5:0] s_hh;
  logic       snz_take, snz_fire;

  assign snz_take = snooze && (|ring_q);
  assign snz_fire = tick && (snz_mask_q != '0) && (cur_hh == snz_hh_q)
                    && (cur_mm == snz_mm_q) && (cur_ss == snz_ss_q);

  always_comb begin
    s_mm = 7'(cur_mm) + 7'(SNOOZE_MIN);
    s_hh = 6'(cur_hh);
    if (s_mm >= 7'd60) begin
      s_mm = s_mm - 7'd60;
      s_hh = s_hh + 6'd1;
    end
    if (s_hh >= 6'd24) s_hh = s_hh - 6'd24;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snz_mask_q <= '0;
      snz_hh_q   <= '0;
      snz_mm_q   <= '0;
      snz_ss_q   <= '0;
    end else if (stop) begin
      snz_mask_q <= '0;
    end else if (snz_take) begin
      snz_mask_q <= ring_q;
      snz_hh_q   <= s_hh[4:0];
      snz_mm_q   <= s_mm[5:0];
      snz_ss_q   <= cur_ss;
    end else if (snz_fire) begin
      snz_mask_q <= '0;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Priority: countdown, then stop/snooze clear, then snooze re-ring, then alarm match wins.
  always_comb begin
    ring_d = ring_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < N_ALARM; i++) begin
      if (tick && ring_q[i]) begin
        if (cnt_q[i] <= CW'(1)) begin
          ring_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
    end
    if (stop) ring_d = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
    if (snz_take) ring_d = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (snz_fire && snz_mask_q[i]) begin
        ring_d[i] = 1'b1;
        cnt_d[i]  = CW'(RING_SEC);
      end
    end
`endif
    for (int i = 0; i < N_ALARM; i++) begin
      if (tick && armed_q[i] && (alm_hh_q[i] == cur_hh) && (alm_mm_q[i] == cur_mm)
          && (alm_ss_q[i] == cur_ss)) begin
        ring_d[i] = 1'b1;
        cnt_d[i]  = CW'(RING_SEC);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_prev_q <= '0;
      code_q     <= '0;
      evt_q      <= 1'b0;
      state_q    <= IDLE;
      dig_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      alm_hh_q   <= '0;
      alm_mm_q   <= '0;
      alm_ss_q   <= '0;
      armed_q    <= '0;
      ring_q     <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      piezo_q    <= 1'b0;
    end else begin
      key_prev_q <= keypad_in;
      code_q     <= keypad_in;
      evt_q      <= (key_prev_q == '0) && onehot;
      state_q    <= state_d;
      dig_q      <= dig_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      err_q      <= commit && !valid;
      for (int i = 0; i < N_ALARM; i++) begin
        if (commit && valid && (ch_sel == 3'(i))) begin
          alm_hh_q[i] <= c_hh[4:0];
          alm_mm_q[i] <= c_mm[5:0];
          alm_ss_q[i] <= c_ss[5:0];
          armed_q[i]  <= 1'b1;
        end
      end
      ring_q <= ring_d;
      cnt_q  <= cnt_d;
      if (|ring_q) begin
        if (div_q == DW'(TONE_DIV - 1)) begin
          div_q   <= '0;
          piezo_q <= ~piezo_q;
        end else begin
          div_q <= div_q + DW'(1);
        end
      end else begin
        div_q   <= '0;
        piezo_q <= 1'b0;
      end
    end
  end

  assign ringing    = ring_q;
  assign armed      = armed_q;
  assign piezo      = piezo_q && (|ring_q);
  assign entry_busy = (state_q != IDLE);
  assign entry_err  = err_q;
endmodule

// File: tb/tb_multi_alarm.sv
// Directed test of multi_alarm with default parameters (4 channels, TONE_DIV=4, RING_SEC=60).
module tb_multi_alarm;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        set_en = 1'b0;
  logic [2:0]  ch_sel = '0;
  logic [11:0] keypad_in = '0;
  logic        tick = 1'b0;
  logic [4:0]  cur_hh = '0;
  logic [5:0]  cur_mm = '0;
  logic [5:0]  cur_ss = '0;
  logic        stop = 1'b0;
  logic        snooze = 1'b0;
  logic [3:0]  ringing, armed;
  logic        piezo, entry_busy, entry_err;
  int checks = 0;
  int failures = 0;

  multi_alarm dut (
    .clk(clk), .resetn(resetn), .set_en(set_en), .ch_sel(ch_sel), .keypad_in(keypad_in),
    .tick(tick), .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss), .stop(stop),
    .snooze(snooze), .ringing(ringing), .armed(armed), .piezo(piezo),
    .entry_busy(entry_busy), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] key_of(input byte c);
    logic [11:0] k;
    k = '0;
    if (c >= "1" && c <= "9") k[c - "1"] = 1'b1;
    else if (c == "*") k[9] = 1'b1;
    else if (c == "0") k[10] = 1'b1;
    else if (c == "#") k[11] = 1'b1;
    return k;
  endfunction

  task automatic press(input byte c);
    keypad_in = key_of(c);
    step();
    keypad_in = '0;
    step();
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    cur_hh = 5'(h);
    cur_mm = 6'(m);
    cur_ss = 6'(s);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ringing", 32'(ringing), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_piezo", 32'(piezo), 0);
    chk("rst_busy", 32'(entry_busy), 0);
    chk("rst_err", 32'(entry_err), 0);
    step();
    resetn = 1'b1;
    step();

    // channel 0 = 10:23:45
    set_en = 1'b1;
    ch_sel = 3'd0;
    keys("1#");
    chk("busy_mid_entry", 32'(entry_busy), 1);
    keys("0#2#3#4#5#*");
    chk("ch0_armed", 32'(armed), 4'b0001);
    chk("ch0_no_err", 32'(entry_err), 0);
    chk("ch0_idle", 32'(entry_busy), 0);

    tick_at(10, 23, 44);
    chk("no_match_off_by_one", 32'(ringing), 0);
    tick_at(10, 23, 45);
    chk("ch0_ring", 32'(ringing), 4'b0001);
    chk("piezo_start", 32'(piezo), 0);
    step(); step(); step();
    chk("piezo_before_toggle", 32'(piezo), 0);
    step();
    chk("piezo_first_toggle", 32'(piezo), 1);
    step(); step(); step(); step();
    chk("piezo_second_toggle", 32'(piezo), 0);

    for (int i = 0; i < 59; i++) begin
      tick_at(0, 0, 0);
      step();
    end
    chk("ring_after_59", 32'(ringing), 4'b0001);
    tick_at(0, 0, 0);
    chk("ring_auto_stop", 32'(ringing), 0);
    chk("piezo_quiet", 32'(piezo), 0);

    // invalid hour 25
    keys("2#5#0#0#0#0#*");
    chk("bad_hh_err", 32'(entry_err), 1);
    chk("bad_hh_idle", 32'(entry_busy), 0);
    step();
    chk("err_one_cycle", 32'(entry_err), 0);
    chk("bad_hh_armed", 32'(armed), 4'b0001);

    ch_sel = 3'd5;
    keys("1#*");
    chk("bad_ch_err", 32'(entry_err), 1);
    chk("bad_ch_armed", 32'(armed), 4'b0001);
    step();

    // channel 1 = 12:00:00 via missing digits
    ch_sel = 3'd1;
    keys("1#2#*");
    chk("ch1_armed", 32'(armed), 4'b0011);
    tick_at(10, 23, 45);
    chk("ch0_unchanged", 32'(ringing), 4'b0001);
    stop = 1'b1;
    tick_at(12, 0, 0);
    stop = 1'b0;
    chk("stop_vs_match", 32'(ringing), 4'b0010);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_clear", 32'(ringing), 0);

    // seventh digit discarded -> 01:02:03
    ch_sel = 3'd2;
    keys("0#1#0#2#0#3#9#*");
    chk("ch2_armed", 32'(armed), 4'b0111);
    tick_at(1, 2, 3);
    chk("ch2_seventh_dropped", 32'(ringing), 4'b0100);
    stop = 1'b1; step(); stop = 1'b0;

    // pending digit replaced, and '*' drops unconfirmed pending -> 23:00:00
    ch_sel = 3'd3;
    keys("92#3#4*");
    chk("ch3_armed", 32'(armed), 4'b1111);
    tick_at(23, 40, 0);
    chk("ch3_pending_dropped", 32'(ringing), 0);
    tick_at(23, 0, 0);
    chk("ch3_ring", 32'(ringing), 4'b1000);
    stop = 1'b1; step(); stop = 1'b0;

    // set_en falling aborts entry
    keys("1#");
    chk("abort_busy_before", 32'(entry_busy), 1);
    set_en = 1'b0;
    step();
    chk("abort_idle", 32'(entry_busy), 0);
    chk("abort_no_err", 32'(entry_err), 0);
    set_en = 1'b1;

    // multi-bit pattern is not a key event
    keypad_in = 12'h003;
    step(); step();
    keypad_in = '0;
    step(); step();
    chk("multibit_ignored", 32'(entry_busy), 0);

    // channel 2 = 23:58:10, then snooze
    ch_sel = 3'd2;
    keys("2#3#5#8#1#0#*");
    tick_at(23, 58, 10);
    chk("ch2_ring_2358", 32'(ringing), 4'b0100);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
    chk("snooze_clears", 32'(ringing), 0);
    tick_at(0, 3, 9);
    chk("snooze_early", 32'(ringing), 0);
    tick_at(0, 3, 10);
    chk("snooze_rering", 32'(ringing), 4'b0100);
`else
    chk("snooze_ignored", 32'(ringing), 4'b0100);
`endif
    stop = 1'b1; step(); stop = 1'b0;
    chk("final_stop", 32'(ringing), 0);

    // asynchronous reset mid-entry
    keys("1#2#");
    chk("pre_reset_busy", 32'(entry_busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_busy", 32'(entry_busy), 0);
    chk("async_rst_armed", 32'(armed), 0);
    chk("async_rst_err", 32'(entry_err), 0);
    step();
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
